convolutor_z_buffer: RTL and testbench



---
 rtl/convolutor_pkg.sv | 16 +
 rtl/convolutor_zbuf_mem.sv | 33 +++
 rtl/convolutor_z_buffer.sv | 189 ++++++++++++++++++
 tb/tb_convolutor_z_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/convolutor_pkg.sv
// Shared types and default widths for the convolution coprocessor Z-result path.
//   ZB_* : states of the Z buffer controller
//   *_DEF / Z_WORD_W : default widths used by the Z buffer when not overridden
package convolutor_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned Z_WORD_W       = 2 * DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        ZB_IDLE    = 2'd0,
        ZB_CAPTURE = 2'd1,
        ZB_DRAIN   = 2'd2
    } zbuf_state_e;

endpackage

// File: rtl/convolutor_zbuf_mem.sv
// Z result storage: DEPTH x WIDTH register array, one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
//   clk        : clock
//   i_we       : write enable
//   i_waddr    : write index
//   i_wdata    : write data
//   i_raddr    : read index
//   o_rdata_c  : combinational read data
module convolutor_zbuf_mem #(
    parameter int unsigned AW    = 6,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2**AW
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/convolutor_z_buffer.sv
// Z buffer behind the convolution coprocessor: captures the Z write stream,
// drains it in index order on a valid/ready stream once done is seen, and
// gates the coprocessor start until the previous set has been drained.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : host start request (accepted only in IDLE)
//   conv_start_o      : one-cycle start pulse to the convolutor
//   conv_done_i       : convolutor done flag
//   z_write_i/addr/data : Z write stream
//   m_valid_o/ready_i/data_o/index_o/last_o : output stream
//   count_o           : number of captured words (highest index + 1)
//   busy_o            : capture or drain in progress
//   done_o            : one-cycle pulse at end of a set
//   err_o             : sticky sequencing error
module convolutor_z_buffer
    import convolutor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = 2**(ADDR_WIDTH+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    output logic                    conv_start_o,
    input  logic                    conv_done_i,
    input  logic                    z_write_i,
    input  logic [ADDR_WIDTH:0]     z_addr_i,
    input  logic [2*DATA_WIDTH-1:0] z_data_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [2*DATA_WIDTH-1:0] m_data_o,
    output logic [ADDR_WIDTH:0]     m_index_o,
    output logic                    m_last_o,
    output logic [ADDR_WIDTH+1:0]   count_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned IW = ADDR_WIDTH + 1;
    localparam int unsigned CW = ADDR_WIDTH + 2;
    localparam int unsigned ZW = 2 * DATA_WIDTH;

    zbuf_state_e   r_state, w_state_n;
    logic [IW-1:0] r_rd, w_rd_n;
    logic [CW-1:0] r_count, w_count_n;
    logic          r_err, w_err_n;
    logic          r_conv_start, w_conv_start_n;
    logic          r_done, w_done_n;
    logic          r_busy, w_busy_n;
    logic          r_m_valid, w_m_valid_n;
    logic [ZW-1:0] r_m_data, w_m_data_n;
    logic [IW-1:0] r_m_index, w_m_index_n;
    logic          r_m_last, w_m_last_n;
    logic          w_we;
    logic          w_load;
    logic [ZW-1:0] w_rdata;

    convolutor_zbuf_mem #(
        .AW    (IW),
        .WIDTH (ZW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (z_addr_i),
        .i_wdata   (z_data_i),
        .i_raddr   (r_rd),
        .o_rdata_c (w_rdata)
    );

    // next-state and next-output logic
    always_comb begin
        w_state_n      = r_state;
        w_rd_n         = r_rd;
        w_count_n      = r_count;
        w_err_n        = r_err;
        w_conv_start_n = 1'b0;
        w_done_n       = 1'b0;
        w_m_valid_n    = r_m_valid;
        w_m_data_n     = r_m_data;
        w_m_index_n    = r_m_index;
        w_m_last_n     = r_m_last;
        w_we           = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            ZB_IDLE: begin
                if (start_i) begin
                    w_conv_start_n = 1'b1;
                    w_count_n      = '0;
                    w_err_n        = 1'b0;
                    w_state_n      = ZB_CAPTURE;
                end
                if (z_write_i) begin
                    w_err_n = 1'b1;
                end
            end
            ZB_CAPTURE: begin
                if (z_write_i) begin
                    w_we      = 1'b1;
                    w_count_n = CW'(z_addr_i) + CW'(1);
                    if (CW'(z_addr_i) != r_count) begin
                        w_err_n = 1'b1;
                    end
                end
                // a write in the done cycle still counts, so the set is non-empty
                if (conv_done_i) begin
                    if (z_write_i || (r_count != '0)) begin
                        w_state_n = ZB_DRAIN;
                        w_rd_n    = '0;
                    end else begin
                        w_state_n = ZB_IDLE;
                        w_done_n  = 1'b1;
                    end
                end
            end
            ZB_DRAIN: begin
                if (z_write_i) begin
                    w_err_n = 1'b1;
                end
                // fill an empty output register, or refill it on a non-final handshake
                if (!r_m_valid) begin
                    w_load = 1'b1;
                end else if (m_ready_i) begin
                    if (r_m_last) begin
                        w_m_valid_n = 1'b0;
                        w_done_n    = 1'b1;
                        w_state_n   = ZB_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
                if (w_load) begin
                    w_m_valid_n = 1'b1;
                    w_m_data_n  = w_rdata;
                    w_m_index_n = r_rd;
                    w_m_last_n  = (CW'(r_rd) == (r_count - CW'(1)));
                    w_rd_n      = r_rd + IW'(1);
                end
            end
            default: begin
                w_state_n = ZB_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != ZB_IDLE);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ZB_IDLE;
            r_rd         <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_conv_start <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_index    <= '0;
            r_m_last     <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_rd         <= w_rd_n;
            r_count      <= w_count_n;
            r_err        <= w_err_n;
            r_conv_start <= w_conv_start_n;
            r_done       <= w_done_n;
            r_busy       <= w_busy_n;
            r_m_valid    <= w_m_valid_n;
            r_m_data     <= w_m_data_n;
            r_m_index    <= w_m_index_n;
            r_m_last     <= w_m_last_n;
        end
    end

    assign conv_start_o = r_conv_start;
    assign count_o      = r_count;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign m_valid_o    = r_m_valid;
    assign m_data_o     = r_m_data;
    assign m_index_o    = r_m_index;
    assign m_last_o     = r_m_last;

endmodule

// File: tb/tb_convolutor_z_buffer.sv
// Self-checking bench for convolutor_z_buffer: a model of the buffer contents
// feeds an expected-word queue at done time; the monitor pops it on handshakes.
module tb_convolutor_z_buffer;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        conv_start_o;
    logic        conv_done_i;
    logic        z_write_i;
    logic [5:0]  z_addr_i;
    logic [15:0] z_data_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [15:0] m_data_o;
    logic [5:0]  m_index_o;
    logic        m_last_o;
    logic [6:0]  count_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_conv_start = 0;
    int          n_start_exp = 0;
    exp_t        sb_q[$];
    bit          rdy_q[$];
    logic [15:0] mdl_mem [64];
    int          mdl_count = 0;
    logic        hold_v;
    logic [22:0] hold_w;

    convolutor_z_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .conv_start_o (conv_start_o),
        .conv_done_i  (conv_done_i),
        .z_write_i    (z_write_i),
        .z_addr_i     (z_addr_i),
        .z_data_i     (z_data_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_index_o    (m_index_o),
        .m_last_o     (m_last_o),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        for (int i = 0; i < mdl_count; i++) begin
            sb_q.push_back('{data: mdl_mem[i], idx: 6'(i), last: (i == mdl_count - 1)});
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_start_exp++;
        mdl_count = 0;
        check("conv_start_pulse", conv_start_o, 1);
        check("err_clear_on_start", err_o, 0);
        check("busy_in_capture", busy_o, 1);
        check("count_clear_on_start", count_o, 0);
        tick();
        check("conv_start_one_cycle", conv_start_o, 0);
    endtask

    task automatic cap_write(input int idx, input logic [15:0] d, input bit with_done);
        z_write_i   = 1'b1;
        z_addr_i    = 6'(idx);
        z_data_i    = d;
        conv_done_i = with_done;
        tick();
        z_write_i   = 1'b0;
        conv_done_i = 1'b0;
        mdl_mem[idx] = d;
        mdl_count    = idx + 1;
        if (with_done) push_expected();
    endtask

    task automatic send_done();
        conv_done_i = 1'b1;
        tick();
        conv_done_i = 1'b0;
        push_expected();
    endtask

    // runs one drain to completion; disturb pokes start and a write mid-drain
    task automatic drain(input int exp_ticks, input bit disturb);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        check("valid_low_after_done", m_valid_o, 0);
        while (n < 300 && !got) begin
            if (m_valid_o && rdy_q.size() > 0) m_ready_i = rdy_q.pop_front();
            else m_ready_i = 1'b1;
            start_i   = disturb && (n == 2);
            z_write_i = disturb && (n == 2);
            z_addr_i  = 6'd1;
            z_data_i  = 16'hDEAD;
            tick();
            n++;
            if (n == 1) check("valid_rise", m_valid_o, 1);
            got = done_o;
        end
        start_i   = 1'b0;
        z_write_i = 1'b0;
        m_ready_i = 1'b1;
        check("drain_done_seen", got, 1);
        check("drain_ticks", n, exp_ticks);
        check("busy_after_drain", busy_o, 0);
        check("valid_after_drain", m_valid_o, 0);
        tick();
        check("done_one_cycle", done_o, 0);
        check("sb_drained", sb_q.size(), 0);
    endtask

    // output monitor: scoreboard pop on handshake, stability under backpressure
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (conv_start_o) n_conv_start++;
            if (hold_v && m_valid_o) check("hold_stable", {m_data_o, m_index_o, m_last_o}, hold_w);
            if (m_valid_o && m_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", {m_data_o, m_index_o, m_last_o}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", m_data_o, e.data);
                    check("out_index", m_index_o, e.idx);
                    check("out_last", m_last_o, e.last);
                end
            end
            hold_v <= m_valid_o && !m_ready_i;
            hold_w <= {m_data_o, m_index_o, m_last_o};
        end
    end

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        conv_done_i = 1'b0;
        z_write_i   = 1'b0;
        z_addr_i    = '0;
        z_data_i    = '0;
        m_ready_i   = 1'b1;
        tick();
        tick();
        check("rst_valid", m_valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_done", done_o, 0);
        check("rst_conv_start", conv_start_o, 0);
        rst = 1'b0;
        tick();

        // basic capture and full-throughput drain
        do_start();
        for (int i = 0; i < 7; i++) cap_write(i, 16'(10 * (i + 1)), 1'b0);
        check("basic_count", count_o, 7);
        send_done();
        drain(8, 1'b0);

        // backpressure
        do_start();
        cap_write(0, 16'h0101, 1'b0);
        cap_write(1, 16'h0202, 1'b0);
        cap_write(2, 16'h0303, 1'b0);
        send_done();
        rdy_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        drain(7, 1'b0);

        // final write coincides with done
        do_start();
        for (int i = 0; i < 4; i++) cap_write(i, 16'(16'h1000 + i), 1'b0);
        cap_write(4, 16'hBEEF, 1'b1);
        check("wd_same_count", count_o, 5);
        drain(6, 1'b0);
        check("err_clean_so_far", err_o, 0);

        // write in IDLE is an error and is not stored
        z_write_i = 1'b1;
        z_addr_i  = 6'd1;
        z_data_i  = 16'h1234;
        tick();
        z_write_i = 1'b0;
        check("idle_write_err", err_o, 1);

        // start and write during drain are ignored; write flags error
        do_start();
        cap_write(0, 16'h0AAA, 1'b0);
        cap_write(1, 16'h0BBB, 1'b0);
        cap_write(2, 16'h0CCC, 1'b0);
        cap_write(3, 16'h0DDD, 1'b0);
        send_done();
        drain(5, 1'b1);
        check("drain_write_err", err_o, 1);
        check("no_start_in_drain", n_conv_start, n_start_exp);

        // non-sequential index: stored, flagged; hole drains model contents
        do_start();
        cap_write(0, 16'h7001, 1'b0);
        check("seq_no_err", err_o, 0);
        cap_write(2, 16'h7003, 1'b0);
        check("nonseq_err", err_o, 1);
        check("nonseq_count", count_o, 3);
        send_done();
        drain(4, 1'b0);

        // empty set
        do_start();
        send_done();
        check("empty_done_pulse", done_o, 1);
        check("empty_busy", busy_o, 0);
        check("empty_valid", m_valid_o, 0);
        tick();
        check("empty_done_one_cycle", done_o, 0);
        check("empty_valid_after", m_valid_o, 0);

        // full set
        do_start();
        for (int i = 0; i < 64; i++) cap_write(i, 16'(i * 257 + 3), 1'b0);
        check("full_count", count_o, 64);
        send_done();
        drain(65, 1'b0);

        // reset in the middle of a drain
        do_start();
        for (int i = 0; i < 7; i++) cap_write(i, 16'(16'h4400 + i), 1'b0);
        send_done();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", m_valid_o, 0);
        check("midrst_count", count_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        rst = 1'b0;
        sb_q.delete();
        tick();
        do_start();
        cap_write(0, 16'h5550, 1'b0);
        cap_write(1, 16'h5551, 1'b0);
        cap_write(2, 16'h5552, 1'b0);
        send_done();
        drain(4, 1'b0);

        check("start_pulse_total", n_conv_start, n_start_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
